// File: rtl/adc_pulse_meter_pkg.sv
// Shared definitions for the ADC pulse meter: state encoding and the sample/counter
// widths agreed with the serial ADC interface stage.
package adc_pulse_meter_pkg;

    localparam int PKG_DW = 10;
    localparam int PKG_CW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

endpackage

// File: rtl/adc_pulse_meter_sat_counter.sv
// Saturating up-counter with load-to-one; holds at all-ones and flags it.
module sat_counter
    import adc_pulse_meter_pkg::*;
#(
    parameter int CW = PKG_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load1,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          sat
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    assign sat = &count;

    // load1 starts a fresh run and takes priority over any increment
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load1) begin
            count <= CNT_ONE;
        end else if (inc && !sat) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/adc_pulse_meter.sv
// Debounced hysteresis threshold on the ADC sample stream, with high/low run-length
// measurement, rising-edge count and sticky run-counter overflow.
module adc_pulse_meter
    import adc_pulse_meter_pkg::*;
#(
    parameter int DW    = PKG_DW,
    parameter int CW    = PKG_CW,
    parameter int DEB_N = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] SAMPLE,
    input  logic          SAMPLE_VALID,
    input  logic [DW-1:0] TH_HI,
    input  logic [DW-1:0] TH_LO,
    input  logic          CLR,
    output logic          LEVEL,
    output logic [CW-1:0] WIDTH,
    output logic          WIDTH_IS_HIGH,
    output logic          WIDTH_VALID,
    output logic [CW-1:0] EDGE_COUNT,
    output logic          OVERFLOW
);

    localparam logic [3:0]    DEB_LAST = 4'(DEB_N - 1);
    localparam logic [CW-1:0] RUN_NEAR = {{(CW-1){1'b1}}, 1'b0};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        state_next;
    logic [3:0]    deb_cnt;
    logic [3:0]    deb_next;
    logic          first;
    logic [CW-1:0] run_cnt;
    logic          run_load;
    logic          run_inc;
    logic          run_sat;
    logic          cand;
    logic          sw;
    logic          sat_evt;

    sat_counter #(
        .CW(CW)
    ) u_run_cnt (
        .clk   (CLK),
        .rst   (RST),
        .load1 (run_load),
        .inc   (run_inc),
        .count (run_cnt),
        .sat   (run_sat)
    );

    // Each settled state only looks for evidence of the opposite level
    always_comb begin
        state_next = state;
        deb_next   = deb_cnt;
        run_load   = 1'b0;
        run_inc    = 1'b0;
        cand       = 1'b0;
        sw         = 1'b0;
        if (SAMPLE_VALID) begin
            case (state)
                ST_IDLE: begin
                    run_load   = 1'b1;
                    deb_next   = 4'd0;
                    state_next = (SAMPLE >= TH_HI) ? ST_HIGH : ST_LOW;
                end
                ST_LOW, ST_HIGH: begin
                    cand = (state == ST_LOW) ? (SAMPLE >= TH_HI) : (SAMPLE <= TH_LO);
                    if (cand && deb_cnt == DEB_LAST) begin
                        sw         = 1'b1;
                        run_load   = 1'b1;
                        deb_next   = 4'd0;
                        state_next = (state == ST_LOW) ? ST_HIGH : ST_LOW;
                    end else begin
                        run_inc  = 1'b1;
                        deb_next = cand ? (deb_cnt + 4'd1) : 4'd0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Reaching all-ones, or trying to count past it, both count as saturation
    assign sat_evt = run_inc && (run_sat || run_cnt == RUN_NEAR);

    assign LEVEL = (state == ST_HIGH);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= ST_IDLE;
            deb_cnt       <= 4'd0;
            first         <= 1'b1;
            WIDTH         <= '0;
            WIDTH_IS_HIGH <= 1'b0;
            WIDTH_VALID   <= 1'b0;
            EDGE_COUNT    <= '0;
            OVERFLOW      <= 1'b0;
        end else begin
            state       <= state_next;
            deb_cnt     <= deb_next;
            WIDTH_VALID <= 1'b0;
            if (sw) begin
                WIDTH         <= run_cnt;
                WIDTH_IS_HIGH <= (state == ST_HIGH);
                // The run that began in IDLE started at an unknown point, so it is not reported
                if (first) begin
                    first <= 1'b0;
                end else begin
                    WIDTH_VALID <= 1'b1;
                end
            end
            if (CLR) begin
                EDGE_COUNT <= '0;
            end else if (sw && state == ST_LOW) begin
                EDGE_COUNT <= EDGE_COUNT + CNT_ONE;
            end
            if (sat_evt) begin
                OVERFLOW <= 1'b1;
            end else if (CLR) begin
                OVERFLOW <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_pulse_meter.sv
// Bench for adc_pulse_meter: three configurations share one stimulus stream and are
// compared every cycle against a per-configuration reference model, plus directed checks.
module tb_adc_pulse_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       valid;
    logic       clr;
    logic [9:0] sample;
    logic [9:0] th_hi;
    logic [9:0] th_lo;

    logic        lvl0, lvl1, lvl2;
    logic [15:0] w0, w1, e0, e1;
    logic [3:0]  w2, e2;
    logic        wih0, wih1, wih2;
    logic        wv0, wv1, wv2;
    logic        ovf0, ovf1, ovf2;

    adc_pulse_meter #(.DW(10), .CW(16), .DEB_N(1)) u_deb1 (
        .CLK(clk), .RST(rst), .SAMPLE(sample), .SAMPLE_VALID(valid),
        .TH_HI(th_hi), .TH_LO(th_lo), .CLR(clr), .LEVEL(lvl0), .WIDTH(w0),
        .WIDTH_IS_HIGH(wih0), .WIDTH_VALID(wv0), .EDGE_COUNT(e0), .OVERFLOW(ovf0)
    );

    adc_pulse_meter #(.DW(10), .CW(16), .DEB_N(3)) u_deb3 (
        .CLK(clk), .RST(rst), .SAMPLE(sample), .SAMPLE_VALID(valid),
        .TH_HI(th_hi), .TH_LO(th_lo), .CLR(clr), .LEVEL(lvl1), .WIDTH(w1),
        .WIDTH_IS_HIGH(wih1), .WIDTH_VALID(wv1), .EDGE_COUNT(e1), .OVERFLOW(ovf1)
    );

    adc_pulse_meter #(.DW(10), .CW(4), .DEB_N(1)) u_cw4 (
        .CLK(clk), .RST(rst), .SAMPLE(sample), .SAMPLE_VALID(valid),
        .TH_HI(th_hi), .TH_LO(th_lo), .CLR(clr), .LEVEL(lvl2), .WIDTH(w2),
        .WIDTH_IS_HIGH(wih2), .WIDTH_VALID(wv2), .EDGE_COUNT(e2), .OVERFLOW(ovf2)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state, one slot per configuration
    int debn[3] = '{1, 3, 1};
    int rmax[3] = '{65535, 65535, 15};
    int emod[3] = '{65536, 65536, 16};
    bit m_on[3];
    int m_lvl[3], m_run[3], m_deb[3], m_first[3];
    int m_w[3], m_wih[3], m_wv[3], m_e[3], m_ovf[3];

    bit collect = 1'b0;
    int sq_w[$];
    int sq_h[$];
    bit wv_seen[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int i);
        bit cand;
        bit rise;
        bit satv;
        if (rst) begin
            m_on[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_deb[i] = 0; m_first[i] = 1;
            m_w[i] = 0; m_wih[i] = 0; m_wv[i] = 0; m_e[i] = 0; m_ovf[i] = 0;
            return;
        end
        m_wv[i] = 0;
        rise = 0;
        satv = 0;
        if (valid) begin
            if (!m_on[i]) begin
                m_on[i] = 1;
                m_lvl[i] = (sample >= th_hi) ? 1 : 0;
                m_run[i] = 1;
                m_deb[i] = 0;
                m_first[i] = 1;
            end else begin
                cand = (m_lvl[i] != 0) ? (sample <= th_lo) : (sample >= th_hi);
                if (cand && (m_deb[i] + 1 == debn[i])) begin
                    m_w[i] = m_run[i];
                    m_wih[i] = m_lvl[i];
                    if (m_first[i] != 0) m_first[i] = 0;
                    else m_wv[i] = 1;
                    rise = (m_lvl[i] == 0);
                    m_lvl[i] = (m_lvl[i] == 0) ? 1 : 0;
                    m_run[i] = 1;
                    m_deb[i] = 0;
                end else begin
                    m_deb[i] = cand ? m_deb[i] + 1 : 0;
                    if (m_run[i] < rmax[i]) m_run[i]++;
                    if (m_run[i] == rmax[i]) satv = 1;
                end
            end
        end
        if (clr) m_e[i] = 0;
        else if (rise) m_e[i] = (m_e[i] + 1) % emod[i];
        if (satv) m_ovf[i] = 1;
        else if (clr) m_ovf[i] = 0;
    endtask

    task automatic check_all();
        logic [31:0] ol[3], ow[3], oh[3], ov[3], oe[3], oo[3];
        ol[0] = lvl0; ol[1] = lvl1; ol[2] = lvl2;
        ow[0] = w0;   ow[1] = w1;   ow[2] = w2;
        oh[0] = wih0; oh[1] = wih1; oh[2] = wih2;
        ov[0] = wv0;  ov[1] = wv1;  ov[2] = wv2;
        oe[0] = e0;   oe[1] = e1;   oe[2] = e2;
        oo[0] = ovf0; oo[1] = ovf1; oo[2] = ovf2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("level[%0d]", i), ol[i], m_lvl[i]);
            chk($sformatf("width_valid[%0d]", i), ov[i], m_wv[i]);
            chk($sformatf("width[%0d]", i), ow[i], m_w[i]);
            chk($sformatf("width_is_high[%0d]", i), oh[i], m_wih[i]);
            chk($sformatf("edge_count[%0d]", i), oe[i], m_e[i]);
            chk($sformatf("overflow[%0d]", i), oo[i], m_ovf[i]);
            if (ov[i] == 1) wv_seen[i] = 1'b1;
        end
        if (collect && wv0) begin
            sq_w.push_back(int'(w0));
            sq_h.push_back(int'(wih0));
        end
    endtask

    task automatic cyc(input logic v, input logic [9:0] s, input logic c);
        valid  = v;
        sample = s;
        clr    = c;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        check_all();
        valid = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic do_rst(input int n);
        rst = 1'b1;
        repeat (n) cyc(1'b0, 10'd0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; clr = 1'b0; sample = '0;
        th_hi = 10'd600; th_lo = 10'd400;

        do_rst(3);
        chk("rst_level", lvl0, 0);
        chk("rst_edge", e1, 0);
        chk("rst_width", w2, 0);

        // Square wave 5 high / 3 low, four periods
        collect = 1'b1;
        repeat (4) begin
            repeat (5) cyc(1'b1, 10'd1000, 1'b0);
            repeat (3) cyc(1'b1, 10'd0, 1'b0);
        end
        collect = 1'b0;
        chk("sq_strobes", sq_w.size(), 6);
        for (int k = 0; k < sq_w.size() && k < 6; k++) begin
            chk($sformatf("sq_width%0d", k), sq_w[k], (k % 2 == 0) ? 3 : 5);
            chk($sformatf("sq_is_high%0d", k), sq_h[k], (k % 2 == 0) ? 0 : 1);
        end
        chk("sq_edges_deb1", e0, 3);
        chk("sq_edges_deb3", e1, 3);

        // Glitch rejection in LOW with three-sample debounce
        do_rst(1);
        cyc(1'b1, 10'd0, 1'b0);
        wv_seen = '{0, 0, 0};
        cyc(1'b1, 10'd1000, 1'b0);
        cyc(1'b1, 10'd1000, 1'b0);
        cyc(1'b1, 10'd0, 1'b0);
        cyc(1'b1, 10'd1000, 1'b0);
        cyc(1'b1, 10'd1000, 1'b0);
        repeat (5) cyc(1'b1, 10'd0, 1'b0);
        chk("glitch_level", lvl1, 0);
        chk("glitch_no_strobe", wv_seen[1], 0);

        // Hysteresis band holds HIGH; a sample at TH_LO releases it
        repeat (4) cyc(1'b1, 10'd1000, 1'b0);
        repeat (6) cyc(1'b1, 10'd500, 1'b0);
        chk("hyst_hold_deb1", lvl0, 1);
        chk("hyst_hold_deb3", lvl1, 1);
        cyc(1'b1, 10'd400, 1'b0);
        chk("hyst_release_deb1", lvl0, 0);
        chk("hyst_pending_deb3", lvl1, 1);
        repeat (2) cyc(1'b1, 10'd400, 1'b0);

        // Run-counter saturation on the 4-bit instance
        do_rst(1);
        cyc(1'b1, 10'd0, 1'b0);
        for (int h = 1; h <= 20; h++) begin
            cyc(1'b1, 10'd1000, 1'b0);
            if (h == 14) chk("ovf_before", ovf2, 0);
            if (h == 15) chk("ovf_rise", ovf2, 1);
        end
        cyc(1'b1, 10'd0, 1'b0);
        chk("sat_width", w2, 15);
        chk("sat_strobe", wv2, 1);
        chk("sat_edges", e2, 1);
        cyc(1'b0, 10'd0, 1'b1);
        chk("clr_overflow", ovf2, 0);
        chk("clr_edges", e2, 0);

        // Reset in the middle of a debounce with gaps between samples
        cyc(1'b1, 10'd0, 1'b0);
        cyc(1'b0, 10'd0, 1'b0);
        cyc(1'b1, 10'd1000, 1'b0);
        cyc(1'b0, 10'd0, 1'b0);
        cyc(1'b1, 10'd1000, 1'b0);
        do_rst(1);
        chk("midrst_level", lvl1, 0);
        chk("midrst_width", w1, 0);
        chk("midrst_edges", e0, 0);
        cyc(1'b0, 10'd0, 1'b0);
        cyc(1'b1, 10'd1000, 1'b0);
        chk("reidle_level", lvl1, 1);
        wv_seen = '{0, 0, 0};
        repeat (3) cyc(1'b1, 10'd0, 1'b0);
        chk("reidle_first_deb1", wv_seen[0], 0);
        chk("reidle_first_deb3", wv_seen[1], 0);
        chk("reidle_fall", lvl1, 0);

        // Randomised runs with noise, gaps, threshold changes, clears and resets
        repeat (80) begin
            int len;
            bit hi;
            len = $urandom_range(1, 25);
            hi  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0) begin
                th_hi = 10'($urandom_range(200, 800));
                th_lo = 10'($urandom_range(150, 850));
            end
            repeat (len) begin
                logic [9:0] s;
                logic       v;
                logic       c;
                case ($urandom_range(0, 9))
                    0:       s = 10'($urandom_range(0, 1023));
                    1:       s = th_hi;
                    2:       s = th_lo;
                    default: s = hi ? 10'($urandom_range(900, 1023)) : 10'($urandom_range(0, 100));
                endcase
                v = $urandom_range(0, 3) != 0;
                c = $urandom_range(0, 30) == 0;
                rst = $urandom_range(0, 150) == 0;
                cyc(v, s, c);
                rst = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_pulse_meter.md
Name: adc_pulse_meter

Overview:
- Downstream consumer of the serial ADC path. Takes each 10-bit sample once its frame has been deserialised and turns the stream into a debounced logic level.
- The threshold uses hysteresis and is qualified over N consecutive samples. The block measures the high and low run lengths in samples.
- It replaces the single-bit threshold tap and ad-hoc run counter with a defined, measurable interface for the capture/display logic.

Parameters:
- DW, 10, sample width in bits.
- CW, 16, run-length / width counter width in bits.
- DEB_N, 2, consecutive qualifying samples needed to switch level; legal range 1..15.

Ports:
- CLK  in  1  system clock, all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- SAMPLE  in  DW  ADC code; sampled only when SAMPLE_VALID=1.
- SAMPLE_VALID  in  1  one-cycle strobe, at most one per ADC frame.
- TH_HI  in  DW  rise threshold (sample >= TH_HI is a high candidate).
- TH_LO  in  DW  fall threshold (sample <= TH_LO is a low candidate).
- CLR  in  1  synchronous clear of OVERFLOW and EDGE_COUNT only.
- LEVEL  out  1  debounced level.
- WIDTH  out  CW  length in samples of the run just completed.
- WIDTH_IS_HIGH  out  1  1 = WIDTH is a high run, 0 = a low run.
- WIDTH_VALID  out  1  one-cycle strobe; WIDTH and WIDTH_IS_HIGH are valid when it is 1.
- EDGE_COUNT  out  CW  count of qualified LOW->HIGH switches; wraps modulo 2^CW.
- OVERFLOW  out  1  sticky; set when a run counter saturates.

Behaviour:
- Reset values:
  - State IDLE, LEVEL=0, WIDTH=0, WIDTH_IS_HIGH=0, WIDTH_VALID=0, EDGE_COUNT=0, OVERFLOW=0.
  - Internal: run_cnt=0, deb_cnt=0, first=1.
- RST mid-run discards any partial run and any pending debounce count; no WIDTH_VALID is issued for it.
- Cycles with SAMPLE_VALID=0 change nothing except that WIDTH_VALID drops to 0.
- FSM states IDLE, LOW, HIGH.
- IDLE, on the first valid sample:
  - SAMPLE >= TH_HI: go to HIGH, LEVEL=1.
  - Otherwise: go to LOW, LEVEL=0.
  - In both cases run_cnt=1, first=1. No debounce applies in IDLE.
- LOW:
  - Only the high candidate is evaluated.
  - A valid sample that is a candidate: if deb_cnt == DEB_N-1, switch (see below); otherwise deb_cnt+1.
  - A valid sample that is not a candidate: deb_cnt=0.
  - Every valid sample that does not cause a switch increments run_cnt.
- HIGH: mirror of LOW, evaluating only the low candidate.
- Because each state evaluates only one candidate, TH_LO >= TH_HI is legal and gives no hysteresis band.
- On a switch, in the same clock edge:
  - WIDTH=run_cnt, WIDTH_IS_HIGH = old level.
  - WIDTH_VALID=1, unless first=1; in that case it stays 0 and first is cleared, because the first run is incomplete.
  - run_cnt=1, deb_cnt=0, LEVEL toggles.
  - EDGE_COUNT+1 on LOW->HIGH switches, including the first.
  - Debounce delay is the same on both edges, so WIDTH equals the true run length.
- Latency: WIDTH_VALID and the LEVEL change are registered, and appear the cycle after the CLK edge that captured the qualifying SAMPLE_VALID. WIDTH_VALID is exactly one cycle wide.
- run_cnt saturates at 2^CW-1:
  - It holds at that value.
  - OVERFLOW is set and stays set until RST or CLR.
  - The WIDTH reported for that run is 2^CW-1.
- CLR together with a switch in the same cycle: EDGE_COUNT=0, and the increment is lost (CLR wins).
- CLR together with a saturation event: OVERFLOW=1 (the set wins).
- Thresholds are sampled live, with no internal latching. A threshold change takes effect on the next valid sample.

Decomposition:
- Shared package holds:
  - State encoding localparams ST_IDLE=2'd0, ST_LOW=2'd1, ST_HIGH=2'd2.
  - DW and CW defaults, shared with the DAC/ADC serial interface stage so sample widths agree.
- One natural sub-module: sat_counter. It is a CW-bit counter with load-1, increment-enable, saturate and a sat flag output. It is instantiated for run_cnt; deb_cnt stays inline.

Test Plan:
- Square wave, DEB_N=1, TH_HI=600, TH_LO=400: samples 1000 x5 then 0 x3, repeated 4 times, all valid.
  - Expect no strobe for the first run.
  - Then WIDTH = 5 (high) / 3 (low), alternating.
  - EDGE_COUNT = 3 after the third rise.
- Same stimulus with DEB_N=3.
  - Widths are still 5/3.
  - Each LEVEL edge lags by 2 samples relative to the DEB_N=1 run.
- Glitch rejection, DEB_N=3, in LOW: high samples H,H,L,H,H, then L x5.
  - Expect no switch, LEVEL stays 0, no WIDTH_VALID.
- Hysteresis: in HIGH, samples of 500 between TH_LO=400 and TH_HI=600.
  - Expect no switch.
  - A sample of 400 with DEB_N=1 switches to LOW.
- Saturation with CW=4: 20 consecutive high samples, then low.
  - OVERFLOW rises on the 15th high sample.
  - The reported WIDTH is 15.
  - CLR then clears OVERFLOW and EDGE_COUNT.
- RST asserted mid-debounce with SAMPLE_VALID gaps.
  - All outputs return to their reset values.
  - The next valid sample re-enters from IDLE with first=1.
